// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and the {cpol,cpha} mode word.
// Used by both spi_slave and spi_master.
package spi_pkg;

  typedef enum logic {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_e;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_e;

  function automatic logic mode_cpol(input spi_mode_e mode);
    logic [1:0] bits;
    bits = mode;
    return bits[1];
  endfunction

  function automatic logic mode_cpha(input spi_mode_e mode);
    logic [1:0] bits;
    bits = mode;
    return bits[0];
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous bus input, with a selectable
// reset value so idle bus levels come out of reset without spurious edges.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: non-blocking assignments make every stage capture its neighbour's
  // pre-edge value; blocking ones would collapse the chain into one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint, all four CPOL/CPHA modes, bus oversampled in the clk
// domain. One-entry transmit buffer, one-cycle receive pulse.
module spi_slave
  import spi_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             sclk,
  input  logic             mosi,
  input  logic             cs_n,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic sclk_s, mosi_s, cs_n_s;
  logic sclk_q, cs_n_q;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(sclk), .q_o(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d_i(mosi), .q_o(mosi_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
    .clk(clk), .rst_n(rst_n), .d_i(cs_n), .q_o(cs_n_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 1'b0;
      cs_n_q <= 1'b1;
    end else begin
      sclk_q <= sclk_s;
      cs_n_q <= cs_n_s;
    end
  end

  spi_state_e       state_q;
  spi_mode_e        mode_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [WIDTH-2:0] rx_sr_q;
  logic [WIDTH-1:0] tx_sr_q, tx_buf_q, rx_data_q;
  logic             buf_full_q, miso_q, miso_oe_q, rx_valid_q, underrun_q, busy_q;

  logic             cs_fall, cs_rise, sclk_edge, lead_edge, trail_edge;
  logic             sample_edge, drive_edge, last_bit, select, reload, load, tx_fire;
  logic [WIDTH-1:0] load_word, rx_next;
  spi_mode_e        sel_mode;

  assign cs_fall     = cs_n_q & ~cs_n_s;
  assign cs_rise     = ~cs_n_q & cs_n_s;
  assign sclk_edge   = sclk_s ^ sclk_q;
  assign lead_edge   = sclk_edge & (sclk_s != mode_cpol(mode_q));
  assign trail_edge  = sclk_edge & (sclk_s == mode_cpol(mode_q));
  assign sample_edge = mode_cpha(mode_q) ? trail_edge : lead_edge;
  assign drive_edge  = mode_cpha(mode_q) ? lead_edge : trail_edge;
  assign last_bit    = (bit_cnt_q == CNT_W'(WIDTH - 1));
  assign rx_next     = {rx_sr_q, mosi_s};
  assign sel_mode    = spi_mode_e'({cpol, cpha});

  // A new word enters the shift register on select and at every word
  // boundary; in CPHA=0 the boundary is the trailing edge after the wrap.
  assign select = (state_q == SPI_IDLE) && cs_fall;
  assign reload = (state_q == SPI_ACTIVE) && !cs_rise &&
                  (mode_cpha(mode_q) ? (sample_edge && last_bit)
                                     : (drive_edge && (bit_cnt_q == '0)));
  assign load      = select || reload;
  assign load_word = buf_full_q ? tx_buf_q : '0;
  assign tx_fire   = tx_valid && !buf_full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SPI_IDLE;
      mode_q     <= SPI_MODE0;
      bit_cnt_q  <= '0;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      tx_buf_q   <= '0;
      rx_data_q  <= '0;
      buf_full_q <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;

      if (tx_fire) begin
        tx_buf_q   <= tx_data;
        buf_full_q <= 1'b1;
      end
      if (load) begin
        if (buf_full_q) buf_full_q <= 1'b0;
        else            underrun_q <= 1'b1;
      end

      case (state_q)
        SPI_IDLE: begin
          if (cs_fall) begin
            state_q   <= SPI_ACTIVE;
            busy_q    <= 1'b1;
            miso_oe_q <= 1'b1;
            mode_q    <= sel_mode;
            bit_cnt_q <= '0;
            if (cpha) begin
              tx_sr_q <= load_word;
              miso_q  <= 1'b0;
            end else begin
              miso_q  <= load_word[WIDTH-1];
              tx_sr_q <= load_word << 1;
            end
          end
        end
        SPI_ACTIVE: begin
          if (cs_rise) begin
            state_q   <= SPI_IDLE;
            busy_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            miso_q    <= 1'b0;
            bit_cnt_q <= '0;
          end else begin
            if (sample_edge) begin
              rx_sr_q <= rx_next[WIDTH-2:0];
              if (last_bit) begin
                rx_data_q  <= rx_next;
                rx_valid_q <= 1'b1;
                bit_cnt_q  <= '0;
              end else begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              end
            end
            if (reload) begin
              if (mode_cpha(mode_q)) begin
                tx_sr_q <= load_word;
              end else begin
                miso_q  <= load_word[WIDTH-1];
                tx_sr_q <= load_word << 1;
              end
            end else if (drive_edge) begin
              miso_q  <= tx_sr_q[WIDTH-1];
              tx_sr_q <= tx_sr_q << 1;
            end
          end
        end
      endcase
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign tx_ready    = ~buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: an SPI master model drives whole cs_n windows while a
// word-level model predicts received words, returned words and underruns.
module tb_spi_slave;

  localparam int H = 6;

  logic       clk, rst_n, cpol, cpha, sclk, mosi, cs_n;
  logic       miso, miso_oe, tx_valid, tx_ready, rx_valid, tx_underrun, busy;
  logic [7:0] tx_data, rx_data;

  spi_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha),
    .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         under_cnt;
  logic [7:0] rx_got [$];
  logic [7:0] m_got  [$];
  logic [7:0] feed_q [$];
  logic [7:0] mbytes [8];
  logic [7:0] sw     [8];
  logic [7:0] last_rx = 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Feeds queued words into the one-entry buffer whenever it is empty.
  initial begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_valid) tx_valid = 1'b0;
      else if (feed_q.size() > 0 && tx_ready && rst_n) begin
        tx_data  = feed_q.pop_front();
        tx_valid = 1'b1;
      end
    end
  end

  initial begin
    under_cnt = 0;
    forever begin
      @(negedge clk);
      if (rx_valid) rx_got.push_back(rx_data);
      if (tx_underrun) under_cnt++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One cs_n window. Words sw[0..n_pre-1] are queued before select, the
  // next n_post after select; stop_bits>0 cuts the window short.
  task automatic window(input logic [1:0] mode, input int n_bytes, input int stop_bits,
                        input bit do_reset, input int n_pre, input int n_post,
                        input string tag);
    int         total_bits, completed, loads, idx, exp_under;
    logic [7:0] exp_word [9];
    logic [7:0] shift_in;
    logic       cap, b_val;
    total_bits = (stop_bits > 0) ? stop_bits : n_bytes * 8;
    completed  = total_bits / 8;
    loads      = completed + 1;
    idx        = 0;
    exp_under  = 0;
    for (int k = 0; k < loads; k++) begin
      if ((k == 0 && n_pre == 0) || idx >= n_pre + n_post) begin
        exp_word[k] = 8'h00;
        exp_under++;
      end else begin
        exp_word[k] = sw[idx];
        idx++;
      end
    end
    rx_got.delete();
    m_got.delete();
    under_cnt = 0;
    shift_in  = 8'h00;

    cpol = mode[1];
    cpha = mode[0];
    sclk = mode[1];
    mosi = 1'b0;
    for (int i = 0; i < n_pre; i++) feed_q.push_back(sw[i]);
    wait_clk(6);
    cs_n = 1'b0;
    wait_clk(H + 2);
    n_checks++;
    if ({busy, miso_oe} !== 2'b11) begin
      n_fail++;
      $display("FAIL %s select: busy,miso_oe=%b required 11", tag, {busy, miso_oe});
    end
    for (int i = n_pre; i < n_pre + n_post; i++) feed_q.push_back(sw[i]);

    for (int b = 0; b < total_bits; b++) begin
      b_val = mbytes[b / 8][7 - (b % 8)];
      if (!cpha) begin
        mosi = b_val;
        wait_clk(H);
        cap  = miso;
        sclk = ~cpol;
        wait_clk(H);
        sclk = cpol;
      end else begin
        wait_clk(H);
        sclk = ~cpol;
        mosi = b_val;
        wait_clk(H);
        cap  = miso;
        sclk = cpol;
      end
      shift_in = {shift_in[6:0], cap};
      if (b % 8 == 7) m_got.push_back(shift_in);
    end
    wait_clk(H);

    if (do_reset) begin
      rst_n = 1'b0;
      wait_clk(1);
      n_checks++;
      if ({miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy} !== 6'b001000) begin
        n_fail++;
        $display("FAIL %s reset outputs: miso,oe,rdy,rxv,und,busy=%b required 001000", tag,
                 {miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy});
      end
      n_checks++;
      if (rx_data !== 8'h00) begin
        n_fail++;
        $display("FAIL %s reset rx_data: got %h required 00", tag, rx_data);
      end
      cs_n = 1'b1;
      wait_clk(4);
      rst_n   = 1'b1;
      last_rx = 8'h00;
      wait_clk(4);
    end else begin
      cs_n = 1'b1;
      wait_clk(8);
    end

    n_checks++;
    if (rx_got.size() != completed) begin
      n_fail++;
      $display("FAIL %s rx count: got %0d required %0d", tag, rx_got.size(), completed);
    end
    for (int j = 0; j < completed && j < rx_got.size(); j++) begin
      n_checks++;
      if (rx_got[j] !== mbytes[j]) begin
        n_fail++;
        $display("FAIL %s rx word %0d: got %h required %h", tag, j, rx_got[j], mbytes[j]);
      end
    end
    for (int j = 0; j < completed && j < m_got.size(); j++) begin
      n_checks++;
      if (m_got[j] !== exp_word[j]) begin
        n_fail++;
        $display("FAIL %s miso word %0d: got %h required %h", tag, j, m_got[j], exp_word[j]);
      end
    end
    n_checks++;
    if (under_cnt != exp_under) begin
      n_fail++;
      $display("FAIL %s underrun pulses: got %0d required %0d", tag, under_cnt, exp_under);
    end
    if (completed > 0) last_rx = mbytes[completed - 1];
    n_checks++;
    if (rx_data !== last_rx) begin
      n_fail++;
      $display("FAIL %s rx_data held: got %h required %h", tag, rx_data, last_rx);
    end
    n_checks++;
    if ({busy, miso_oe, miso, tx_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL %s deselect: busy,oe,miso,rdy=%b required 0001", tag,
               {busy, miso_oe, miso, tx_ready});
    end
  endtask

  task automatic test_reset();
    wait_clk(3);
    n_checks++;
    if ({miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy} !== 6'b001000) begin
      n_fail++;
      $display("FAIL reset outputs: miso,oe,rdy,rxv,und,busy=%b required 001000",
               {miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy});
    end
    n_checks++;
    if (rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset rx_data: got %h required 00", rx_data);
    end
    rst_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_mode0_single();
    mbytes[0] = 8'hA5; sw[0] = 8'h5A;
    window(2'b00, 1, 0, 1'b0, 1, 0, "mode0");
  endtask

  task automatic test_mode3_single();
    mbytes[0] = 8'h3C; sw[0] = 8'hC3;
    window(2'b11, 1, 0, 1'b0, 1, 0, "mode3");
  endtask

  task automatic test_back_to_back();
    mbytes[0] = 8'h12; mbytes[1] = 8'h34; sw[0] = 8'h81; sw[1] = 8'h7E;
    window(2'b01, 2, 0, 1'b0, 1, 1, "b2b_mode1");
    window(2'b10, 2, 0, 1'b0, 1, 1, "b2b_mode2");
  endtask

  task automatic test_underrun();
    mbytes[0] = 8'($urandom); sw[0] = 8'hEE;
    window(2'b00, 1, 0, 1'b0, 0, 1, "underrun");
  endtask

  task automatic test_abort();
    mbytes[0] = 8'($urandom); sw[0] = 8'h55;
    window(2'b00, 1, 4, 1'b0, 1, 0, "abort");
    mbytes[0] = 8'hF0; sw[0] = 8'h0F;
    window(2'b00, 1, 0, 1'b0, 1, 0, "after_abort");
  endtask

  task automatic test_reset_mid();
    mbytes[0] = 8'($urandom); sw[0] = 8'h66;
    window(2'b10, 1, 3, 1'b1, 1, 0, "reset_mid");
    mbytes[0] = 8'h99; sw[0] = 8'h24;
    window(2'b00, 1, 0, 1'b0, 1, 0, "after_reset");
  endtask

  task automatic test_random();
    int n_bytes, n_pre, n_post;
    for (int t = 0; t < 6; t++) begin
      n_bytes = $urandom_range(1, 3);
      n_pre   = $urandom_range(0, 2);
      n_post  = $urandom_range(0, n_bytes + 1 - n_pre - ((n_pre == 0) ? 1 : 0));
      for (int i = 0; i < 8; i++) begin
        mbytes[i] = 8'($urandom);
        sw[i]     = 8'($urandom);
      end
      window(2'($urandom_range(0, 3)), n_bytes, 0, 1'b0, n_pre, n_post, "random");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cpol  = 1'b0;
    cpha  = 1'b0;
    sclk  = 1'b0;
    mosi  = 1'b0;
    cs_n  = 1'b1;
    test_reset();
    test_mode0_single();
    test_mode3_single();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave endpoint that sits on the far side of the SPI bus from `spi_master`. It consumes `sclk`, `mosi` and `cs_n` and returns `miso`. All bus inputs are oversampled in the system clock domain, and the block supports all four CPOL/CPHA modes. It presents received bytes as a one-cycle valid pulse and takes transmit bytes through a one-entry valid/ready buffer.

## Interface
- `WIDTH`, 8: bits per SPI word.
- `SYNC_STAGES`, 2: flops in each input synchronizer (≥2).
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `cpol` in 1: clock idle level. Latched on the synchronized `cs_n` falling edge.
- `cpha` in 1: 0 = sample on leading edge, 1 = sample on trailing edge. Latched on the synchronized `cs_n` falling edge.
- `sclk`, `mosi`, `cs_n` in 1 each: SPI bus inputs, asynchronous to `clk`.
- `miso` out 1: serial data out, MSB first. Forced to 0 while deselected.
- `miso_oe` out 1: high while selected (synchronized `cs_n` = 0).
- `tx_data` in WIDTH: next word to transmit.
- `tx_valid` in 1, `tx_ready` out 1: handshake. A word is accepted when both are high. `tx_ready` = buffer empty.
- `rx_data` out WIDTH: last complete received word. Held until the next completion.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `tx_underrun` out 1: one-cycle pulse when a word starts with the buffer empty.
- `busy` out 1: high from the selected edge to the deselected edge.

## Operation
- **Synchronizers:** `sclk`, `mosi` and `cs_n` each pass through SYNC_STAGES flops. Edge detection uses the last synchronized stage against one further registered copy.
- **Edge classes:**
  - Leading edge = synchronized `sclk` leaves the latched `cpol` level.
  - Trailing edge = it returns to that level.
  - Sample edge = leading if `cpha`=0, else trailing.
  - Drive edge = the other one.
- **FSM states:** IDLE, ACTIVE.
  - IDLE → ACTIVE on the synchronized `cs_n` falling edge. This latches `cpol`/`cpha`, clears the bit counter and loads the word.
  - ACTIVE → IDLE on the synchronized `cs_n` rising edge, from any bit position.
- **Word load:**
  - If the buffer is full, the shift register takes the buffer and the buffer empties (`tx_ready` rises next cycle).
  - If the buffer is empty, the shift register loads all-zeros and `tx_underrun` pulses.
- **CPHA=0 drive sequence:**
  - Load occurs on the select edge; `miso` shows the MSB the same cycle.
  - Trailing edges 1..WIDTH-1 drive the remaining bits.
  - Trailing edge WIDTH loads the next word and drives its MSB.
- **CPHA=1 drive sequence:**
  - Load occurs on the select edge and again after every completed word. `miso` holds 0 until the first drive edge.
  - Leading edges 1..WIDTH drive bits MSB..LSB.
- **Receive:**
  - On each sample edge, shift the synchronized `mosi` in at the LSB and increment the bit counter (width clog2(WIDTH)+1).
  - On the WIDTH-th sample: `rx_data` ← shifted word, `rx_valid` pulses, counter wraps to 0. Back-to-back words continue while selected.
- **Abort:** deselect mid-word discards the partial word (no `rx_valid`) and clears the counter. The tx buffer is untouched.
- **Buffer write:** `tx_valid`&&`tx_ready` in the same cycle as a load writes the buffer. The load sees the buffer as empty.

## Timing
- **Reset values:** FSM=IDLE, `miso`=0, `miso_oe`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `tx_underrun`=0, `busy`=0, all synchronizer flops=1 except `sclk`=0. `cpol`/`cpha` latches reset to 0.
- **Reset mid-transfer:** immediate return to reset values. Any buffered tx word is lost.
- **Input latency:** a bus edge is acted on SYNC_STAGES+1 `clk` cycles after it occurs.
  - `rx_valid` is high SYNC_STAGES+2 cycles after the last sample edge.
  - `miso` changes SYNC_STAGES+2 cycles after a drive edge or select edge.
- **Bus requirements:**
  - `sclk` high and low phases ≥ SYNC_STAGES+3 `clk` cycles.
  - `cs_n` to first `sclk` edge ≥ SYNC_STAGES+3 cycles.
  - `mosi` stable one full `sclk` half-period around the sample edge.
- **Simultaneous events:** deselect in the same cycle as a sample edge is a deselect; the sample is ignored.

## Structure
- Package `spi_pkg`: FSM state enum (`SPI_IDLE`, `SPI_ACTIVE`) and the mode encoding (`mode = {cpol,cpha}`). `spi_master` shares this package.
- Sub-module `spi_sync`: a parameterized SYNC_STAGES-flop synchronizer with asynchronous reset value parameter. Instantiated three times.

## Test plan
- **Mode 0, single byte:** `tx_data`=0x5A preloaded, bench master sends 0xA5 (half-period 6 clk) → `rx_data`=0xA5 with one `rx_valid` pulse; master receives 0x5A.
- **Mode 3, single byte:** `tx_data`=0xC3, master sends 0x3C → `rx_data`=0x3C, master receives 0xC3.
- **Modes 1 and 2, back-to-back:** two bytes 0x12, 0x34 in one `cs_n` window, tx 0x81 then 0x7E reloaded after the first `rx_valid` → two `rx_valid` pulses in order; master receives 0x81, 0x7E.
- **Underrun:** buffer empty at select → `tx_underrun` pulses once, master receives 0x00, `rx_data` still correct.
- **Abort:** deselect after 4 bits → no `rx_valid`, `busy` falls, `rx_data` unchanged. The next full byte 0xF0 is received correctly.
- **Reset mid-byte:** `rst_n` low after 3 bits → all outputs at reset values; a fresh transfer of 0x99 succeeds.
